// File: rtl/push_btn_multi_press_pkg.sv
// -----------------------------------------------------------------------------
// push_btn_pkg
// Shared definitions for the multi-press burst counter:
//   state_t              - FSM state encoding (IDLE, COUNT, HOLD)
//   DefaultTimeoutCycles - default idle gap that closes a burst
//   DefaultCountWidth    - default width of the press counter
//   timerWidth()         - bits needed for a timer counting 0..cycles-1
// -----------------------------------------------------------------------------
package push_btn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DefaultTimeoutCycles = 16;
    localparam int DefaultCountWidth    = 3;

    // A timer that only ever reaches cycles-1 needs clog2(cycles) bits,
    // but never less than one bit so the register stays well formed.
    function automatic int timerWidth(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/push_btn_multi_press_if.sv
// -----------------------------------------------------------------------------
// push_btn_multi_press_if
// Bundles the press input, the valid/ready burst result and the status flags.
//   button_pressed - one-cycle press pulse from the debouncer
//   press_ready    - consumer accepts the pending result
//   press_count    - number of presses in the completed burst
//   press_valid    - burst result available
//   busy           - a burst is being counted
//   dropped        - a press was discarded while a result was pending
// master: the surrounding system (drives pulses and ready)
// slave : the burst counter
// -----------------------------------------------------------------------------
interface push_btn_multi_press_if #(
    parameter int CountWidth = 3
) ();

    logic                  button_pressed;
    logic                  press_ready;
    logic [CountWidth-1:0] press_count;
    logic                  press_valid;
    logic                  busy;
    logic                  dropped;

    modport master (
        output button_pressed,
        output press_ready,
        input  press_count,
        input  press_valid,
        input  busy,
        input  dropped
    );

    modport slave (
        input  button_pressed,
        input  press_ready,
        output press_count,
        output press_valid,
        output busy,
        output dropped
    );

endinterface

// File: rtl/push_btn_multi_press_gap_timer.sv
// -----------------------------------------------------------------------------
// push_btn_gap_timer
// Counts idle cycles inside a burst; o_expired flags the last idle cycle.
//   clock     - system clock, rising edge
//   reset     - asynchronous, active-low reset
//   i_clear   - force the timer back to zero (has priority over i_enable)
//   i_enable  - advance the timer by one
//   o_expired - high while the timer sits at TimeoutCycles-1
// -----------------------------------------------------------------------------
module push_btn_gap_timer
    import push_btn_pkg::*;
#(
    parameter int TimeoutCycles = DefaultTimeoutCycles
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int                    TimerWidth = timerWidth(TimeoutCycles);
    localparam logic [TimerWidth-1:0] LastCount  = TimerWidth'(TimeoutCycles - 1);

    logic [TimerWidth-1:0] r_timer;

    // The timer stops at LastCount so it can never run past the timeout,
    // even if the owner keeps it enabled for an extra cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
        end else if (i_clear) begin
            r_timer <= '0;
        end else if (i_enable && (r_timer != LastCount)) begin
            r_timer <= r_timer + TimerWidth'(1);
        end
    end

    assign o_expired = (r_timer == LastCount);

endmodule

// File: rtl/push_btn_multi_press.sv
// -----------------------------------------------------------------------------
// push_btn_multi_press
// Groups debounced press pulses that are closer together than TimeoutCycles
// into one burst and reports the burst size over a valid/ready handshake.
//   clock - system clock, rising edge
//   reset - asynchronous, active-low reset
//   bus   - push_btn_multi_press_if.slave (pulse in, burst result out, status)
// -----------------------------------------------------------------------------
module push_btn_multi_press
    import push_btn_pkg::*;
#(
    parameter int TimeoutCycles = DefaultTimeoutCycles,
    parameter int CountWidth    = DefaultCountWidth
) (
    input  logic                    clock,
    input  logic                    reset,
    push_btn_multi_press_if.slave   bus
);

    localparam logic [CountWidth-1:0] CountMax = '1;
    localparam logic [CountWidth-1:0] CountOne = CountWidth'(1);

    state_t                r_state;
    logic [CountWidth-1:0] r_count;
    logic [CountWidth-1:0] r_pressCount;
    logic                  r_pressValid;
    logic                  r_busy;
    logic                  r_dropped;

    logic                  w_expired;
    logic                  w_timerClear;
    logic                  w_timerEnable;
    logic                  w_transfer;

    // The timer only runs while counting; every press and the timeout itself
    // restart it, and outside COUNT it is held at zero so a new burst always
    // starts from a clean gap.
    assign w_timerEnable = (r_state == COUNT);
    assign w_timerClear  = (r_state != COUNT) | bus.button_pressed | w_expired;
    assign w_transfer    = r_pressValid & bus.press_ready;

    push_btn_gap_timer #(
        .TimeoutCycles (TimeoutCycles)
    ) u_gapTimer (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_timerClear),
        .i_enable  (w_timerEnable),
        .o_expired (w_expired)
    );

    // Burst state machine. A press arriving together with the timeout keeps
    // the burst open; a press during HOLD is only counted if the pending
    // result leaves in the same cycle, otherwise it is reported as dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_pressCount <= '0;
            r_pressValid <= 1'b0;
            r_busy       <= 1'b0;
            r_dropped    <= 1'b0;
        end else begin
            r_dropped <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.button_pressed) begin
                        r_state <= COUNT;
                        r_count <= CountOne;
                        r_busy  <= 1'b1;
                    end
                end
                COUNT: begin
                    if (bus.button_pressed) begin
                        if (r_count != CountMax) begin
                            r_count <= r_count + CountOne;
                        end
                    end else if (w_expired) begin
                        r_state      <= HOLD;
                        r_pressCount <= r_count;
                        r_pressValid <= 1'b1;
                        r_count      <= '0;
                        r_busy       <= 1'b0;
                    end
                end
                HOLD: begin
                    if (w_transfer) begin
                        r_pressValid <= 1'b0;
                        if (bus.button_pressed) begin
                            r_state <= COUNT;
                            r_count <= CountOne;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (bus.button_pressed) begin
                        r_dropped <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_count      <= '0;
                    r_pressValid <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.press_count = r_pressCount;
    assign bus.press_valid = r_pressValid;
    assign bus.busy        = r_busy;
    assign bus.dropped     = r_dropped;

endmodule

// File: tb/tb_push_btn_multi_press.sv
// -----------------------------------------------------------------------------
// tb_push_btn_multi_press
// Directed bench for push_btn_multi_press (TimeoutCycles=16, CountWidth=3).
// A table of {inputs, cycles, expected outputs} rows is replayed edge by edge,
// followed by a hand-written reset-in-the-middle-of-a-burst sequence.
// -----------------------------------------------------------------------------
module tb_push_btn_multi_press;

    localparam int TimeoutCycles = 16;
    localparam int CountWidth    = 3;

    typedef struct {
        string name;
        bit    pressed;
        bit    ready;
        int    cycles;
        bit    expValid;
        int    expCount;
        bit    expBusy;
        bit    expDropped;
    } vec_t;

    logic clock;
    logic reset;
    int   total;
    int   bad;
    vec_t vecs[$];

    push_btn_multi_press_if #(.CountWidth(CountWidth)) bus ();

    push_btn_multi_press #(
        .TimeoutCycles (TimeoutCycles),
        .CountWidth    (CountWidth)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case something stalls the main sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void addVec(input string name, input bit p, input bit r,
                                   input int n, input bit v, input int c,
                                   input bit b, input bit d);
        vec_t x;
        x.name       = name;
        x.pressed    = p;
        x.ready      = r;
        x.cycles     = n;
        x.expValid   = v;
        x.expCount   = c;
        x.expBusy    = b;
        x.expDropped = d;
        vecs.push_back(x);
    endfunction

    task automatic checkOne(input string what, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", what, actual, expected);
        end
    endtask

    // Outputs are sampled 1 unit after the rising edge; the count is only
    // meaningful while the result is valid, so it is compared only then.
    task automatic checkOutput(input string tag, input bit v, input int c,
                               input bit b, input bit d);
        checkOne({tag, " press_valid"}, int'(bus.press_valid), int'(v));
        checkOne({tag, " busy"},        int'(bus.busy),        int'(b));
        checkOne({tag, " dropped"},     int'(bus.dropped),     int'(d));
        if (v) begin
            checkOne({tag, " press_count"}, int'(bus.press_count), c);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input vec_t x);
        for (int k = 0; k < x.cycles; k++) begin
            bus.button_pressed = x.pressed;
            bus.press_ready    = x.ready;
            tick();
            checkOutput($sformatf("%s[%0d]", x.name, k), x.expValid, x.expCount,
                        x.expBusy, x.expDropped);
        end
        bus.button_pressed = 1'b0;
    endtask

    initial begin
        int waited;

        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.button_pressed = 1'b0;
        bus.press_ready    = 1'b1;

        // single press: pulse on edge 10, result after edge 26
        addVec("idle",          0, 1, 9,  0, 0, 0, 0);
        addVec("single press",  1, 1, 1,  0, 0, 1, 0);
        addVec("single count",  0, 1, 15, 0, 0, 1, 0);
        addVec("single result", 0, 1, 1,  1, 1, 0, 0);
        addVec("single accept", 0, 1, 1,  0, 0, 0, 0);
        // double press: pulses 10 edges apart
        addVec("gap a",         0, 1, 5,  0, 0, 0, 0);
        addVec("double p1",     1, 1, 1,  0, 0, 1, 0);
        addVec("double wait",   0, 1, 9,  0, 0, 1, 0);
        addVec("double p2",     1, 1, 1,  0, 0, 1, 0);
        addVec("double count",  0, 1, 15, 0, 0, 1, 0);
        addVec("double result", 0, 1, 1,  1, 2, 0, 0);
        addVec("double accept", 0, 1, 1,  0, 0, 0, 0);
        // pulse on the very edge the timeout would fire: burst continues
        addVec("gap b",         0, 1, 3,  0, 0, 0, 0);
        addVec("edge p1",       1, 1, 1,  0, 0, 1, 0);
        addVec("edge wait",     0, 1, 15, 0, 0, 1, 0);
        addVec("edge p2",       1, 1, 1,  0, 0, 1, 0);
        addVec("edge count",    0, 1, 15, 0, 0, 1, 0);
        addVec("edge result",   0, 1, 1,  1, 2, 0, 0);
        addVec("edge accept",   0, 1, 1,  0, 0, 0, 0);
        // pulse one edge later: two bursts of one
        addVec("gap c",         0, 1, 3,  0, 0, 0, 0);
        addVec("split p1",      1, 1, 1,  0, 0, 1, 0);
        addVec("split wait",    0, 1, 15, 0, 0, 1, 0);
        addVec("split res1",    0, 1, 1,  1, 1, 0, 0);
        addVec("split p2",      1, 1, 1,  0, 0, 1, 0);
        addVec("split count",   0, 1, 15, 0, 0, 1, 0);
        addVec("split res2",    0, 1, 1,  1, 1, 0, 0);
        addVec("split accept",  0, 1, 1,  0, 0, 0, 0);
        // saturation: nine presses four edges apart
        addVec("gap d",         0, 1, 3,  0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            addVec($sformatf("sat p%0d", i), 1, 1, 1, 0, 0, 1, 0);
            addVec($sformatf("sat w%0d", i), 0, 1, 3, 0, 0, 1, 0);
        end
        addVec("sat p8",        1, 1, 1,  0, 0, 1, 0);
        addVec("sat count",     0, 1, 15, 0, 0, 1, 0);
        addVec("sat result",    0, 1, 1,  1, 7, 0, 0);
        addVec("sat accept",    0, 1, 1,  0, 0, 0, 0);
        // backpressure: result stalls, extra press dropped, then accept+press
        addVec("gap e",         0, 0, 3,  0, 0, 0, 0);
        addVec("bp press",      1, 0, 1,  0, 0, 1, 0);
        addVec("bp count",      0, 0, 15, 0, 0, 1, 0);
        addVec("bp result",     0, 0, 1,  1, 1, 0, 0);
        addVec("bp stall",      0, 0, 2,  1, 1, 0, 0);
        addVec("bp drop",       1, 0, 1,  1, 1, 0, 1);
        addVec("bp after drop", 0, 0, 2,  1, 1, 0, 0);
        addVec("bp accept+p",   1, 1, 1,  0, 0, 1, 0);
        addVec("bp count2",     0, 1, 15, 0, 0, 1, 0);
        addVec("bp result2",    0, 1, 1,  1, 1, 0, 0);
        addVec("bp accept",     0, 1, 1,  0, 0, 0, 0);

        // reset state
        repeat (3) tick();
        checkOne("reset press_valid", int'(bus.press_valid), 0);
        checkOne("reset press_count", int'(bus.press_count), 0);
        checkOne("reset busy",        int'(bus.busy),        0);
        checkOne("reset dropped",     int'(bus.dropped),     0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
        end

        // reset asserted in the middle of a two-press burst
        bus.press_ready    = 1'b1;
        bus.button_pressed = 1'b1;
        tick();
        bus.button_pressed = 1'b0;
        repeat (3) tick();
        bus.button_pressed = 1'b1;
        tick();
        bus.button_pressed = 1'b0;
        repeat (4) tick();
        checkOne("pre-reset busy", int'(bus.busy), 1);
        reset = 1'b0;
        #1;
        checkOne("async reset busy",  int'(bus.busy),        0);
        checkOne("async reset valid", int'(bus.press_valid), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOne($sformatf("in reset[%0d] busy", k),  int'(bus.busy),        0);
            checkOne($sformatf("in reset[%0d] valid", k), int'(bus.press_valid), 0);
        end
        reset = 1'b1;
        for (int k = 0; k < TimeoutCycles + 4; k++) begin
            tick();
            checkOne($sformatf("post reset[%0d] valid", k), int'(bus.press_valid), 0);
        end

        // next press after reset gives a fresh burst of one
        bus.button_pressed = 1'b1;
        tick();
        bus.button_pressed = 1'b0;
        checkOne("recover busy", int'(bus.busy), 1);
        waited = 0;
        while (!bus.press_valid && waited < 40) begin
            tick();
            waited++;
        end
        checkOne("recover latency", waited, TimeoutCycles);
        checkOne("recover press_count", int'(bus.press_count), 1);
        tick();
        checkOne("recover accept valid", int'(bus.press_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/push_btn_multi_press.md
Name: push_btn_multi_press

Overview:
- Sits directly downstream of the push-button interface stage and consumes its one-cycle `button_pressed` pulses.
- Groups pulses separated by less than a timeout gap into one burst (single, double, triple press, ...).
- Presents the burst size on a valid/ready output to the control logic.
- Lets one physical button drive several commands.

Parameters:
- TimeoutCycles, 16: idle gap, in clock cycles, that closes a burst; legal range 2..65535.
- CountWidth, 3: width of the press counter; maximum reportable burst is 2^CountWidth-1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- button_pressed  input  1  one-cycle press pulse from the upstream debouncer, synchronous to clock.
- press_count  output  CountWidth  number of presses in the completed burst; valid while press_valid=1.
- press_valid  output  1  burst result available.
- press_ready  input  1  consumer accepts the result; transfer occurs when press_valid & press_ready at a rising edge.
- busy  output  1  high while a burst is being counted (state COUNT).
- dropped  output  1  one-cycle pulse when a press is discarded because a result is pending.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, count=0, timer=0, press_count=0, press_valid=0, busy=0, dropped=0.
- All outputs are registered.
- IDLE:
  - button_pressed=1 -> COUNT with count=1, timer=0.
  - Otherwise remain in IDLE.
- COUNT:
  - button_pressed=1 -> count=count+1, saturating at 2^CountWidth-1 (no wrap); timer=0.
  - Otherwise timer=timer+1.
  - timer==TimeoutCycles-1 and button_pressed=0 -> HOLD, press_count=count, press_valid=1, count=0, timer=0.
  - Simultaneous pulse and timeout: the pulse wins (increment, timer cleared, stay in COUNT).
  - Latency: press_valid rises exactly TimeoutCycles edges after the edge that sampled the last pulse.
- HOLD:
  - press_valid=1 and press_count are held stable until transfer.
  - button_pressed=1 without transfer in the same cycle -> dropped=1 for one cycle; the press is not counted.
  - Transfer and button_pressed=1 in the same cycle -> press_valid=0, COUNT with count=1, timer=0, dropped=0.
  - Transfer only -> press_valid=0, IDLE.
- press_ready is ignored while press_valid=0.
- A consumer holding press_ready=1 permanently costs one cycle of HOLD per burst.
- busy=1 exactly when state==COUNT.
- Timer width: clog2(TimeoutCycles); the timer never exceeds TimeoutCycles-1.
- Reset asserted mid-burst or during HOLD: the burst and the pending result are discarded and no output pulse is generated; operation resumes from IDLE on the first edge after reset deasserts.

Decomposition:
- Package push_btn_pkg holds:
  - the state encoding (IDLE, COUNT, HOLD) as a 2-bit enumerated typedef;
  - the default TimeoutCycles and CountWidth constants;
  - the timer-width function.
- One sub-module, push_btn_gap_timer:
  - clear/enable inputs and an `expired` output that is high when timer==TimeoutCycles-1;
  - instantiated once and shared by the state machine.

Test Plan (TimeoutCycles=16, CountWidth=3, press_ready=1 unless stated):
- Single press: pulse at edge 10 -> press_valid=1, press_count=1 after edge 26, low after edge 27; busy=1 between edges 10 and 26.
- Double press: pulses at edges 10 and 20 -> exactly one result, press_count=2, press_valid rising after edge 36.
- Boundary gap: pulses at edges 10 and 26 (timeout and pulse coincide) -> one burst of 2, result after edge 42; pulses at 10 and 27 -> two results, both press_count=1.
- Saturation: 9 pulses spaced 4 cycles apart -> single result press_count=7, no wrap to 1.
- Backpressure: press_ready=0, burst of 1, then pulse during HOLD -> dropped pulses once, press_count stays 1; press_ready=1 together with a new pulse -> transfer occurs and a new burst starts with count=1, dropped=0.
- Reset mid-burst: 2 pulses, then reset low for 3 cycles before timeout -> press_valid never asserts, busy=0 immediately on reset assertion; the next pulse yields press_count=1.
